// File: rtl/hazard_forward_unit.sv
// EX-stage operand forwarding and load-use stall control for the pipelined MIPS core.
// Tracks in-flight register writers in a private EX -> entry 1..FWD_DEPTH shift pipeline.
module hazard_forward_unit #(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned FWD_DEPTH  = 3,
    parameter int unsigned LOAD_STAGE = 2,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned SELW      = $clog2(FWD_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      freeze,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic                      id_regwrite,
    input  logic [REG_AW-1:0]         id_wr_reg,
    input  logic                      id_is_load,
    output logic                      stall,
    output logic [NUM_SRC*SELW-1:0]   fwd_sel,
    output logic [CNT_W-1:0]          stall_count
);

    // One extra bit so (position + 1) never overflows when compared against avail.
    localparam int unsigned CMPW = SELW + 1;

    // EX stage copy of the instruction being executed
    logic                             ex_valid;
    logic                             ex_regwrite;
    logic                             ex_is_load;
    logic [REG_AW-1:0]                ex_wr_reg;
    logic [NUM_SRC-1:0][REG_AW-1:0]   ex_src;
    logic [NUM_SRC-1:0]               ex_src_used;

    // Writers that have left EX; entry k is k stages past EX
    logic [FWD_DEPTH:1]               ent_valid;
    logic [FWD_DEPTH:1]               ent_regwrite;
    logic [REG_AW-1:0]                ent_wr_reg [1:FWD_DEPTH];
    logic [SELW-1:0]                  ent_avail  [1:FWD_DEPTH];

    logic [NUM_SRC-1:0][REG_AW-1:0]   id_src_arr;
    logic                             ex_live;
    logic [FWD_DEPTH:1]               ent_live;
    logic [SELW-1:0]                  ex_avail;
    logic [NUM_SRC-1:0]               op_hazard;

    assign id_src_arr = id_src;
    assign ex_avail   = ex_is_load ? SELW'(LOAD_STAGE) : SELW'(1);
    assign ex_live    = ex_valid && ex_regwrite && (ex_wr_reg != '0);

    always_comb begin
        ent_live = '0;
        for (int k = 1; k <= int'(FWD_DEPTH); k++) begin
            ent_live[k] = ent_valid[k] && ent_regwrite[k] && (ent_wr_reg[k] != '0);
        end
    end

    // Youngest live writer of each ID operand decides whether its data is ready in time.
    always_comb begin
        logic found;
        op_hazard = '0;
        found     = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            found = 1'b0;
            if (ex_live && (ex_wr_reg == id_src_arr[i])) begin
                found = 1'b1;
                if (CMPW'(1) < CMPW'(ex_avail)) begin
                    op_hazard[i] = 1'b1;
                end
            end
            for (int k = 1; k <= int'(FWD_DEPTH); k++) begin
                if (!found && ent_live[k] && (ent_wr_reg[k] == id_src_arr[i])) begin
                    found = 1'b1;
                    if (CMPW'(k + 1) < CMPW'(ent_avail[k])) begin
                        op_hazard[i] = 1'b1;
                    end
                end
            end
        end
        stall = id_valid && !flush && |(op_hazard & id_src_used);
    end

    // Bypass select per EX operand: nearest (smallest k) live writer wins.
    always_comb begin
        logic [SELW-1:0] sel;
        fwd_sel = '0;
        sel     = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            sel = '0;
            for (int k = int'(FWD_DEPTH); k >= 1; k--) begin
                if (ent_live[k] && (ent_wr_reg[k] == ex_src[i])) begin
                    sel = SELW'(k);
                end
            end
            if (ex_valid && ex_src_used[i]) begin
                fwd_sel[i*SELW +: SELW] = sel;
            end
        end
    end

    // Pipeline tracking state and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_regwrite  <= 1'b0;
            ex_is_load   <= 1'b0;
            ex_wr_reg    <= '0;
            ex_src       <= '0;
            ex_src_used  <= '0;
            ent_valid    <= '0;
            ent_regwrite <= '0;
            for (int k = 1; k <= int'(FWD_DEPTH); k++) begin
                ent_wr_reg[k] <= '0;
                ent_avail[k]  <= '0;
            end
            stall_count  <= '0;
        end else if (!freeze) begin
            ent_valid[1]    <= ex_valid;
            ent_regwrite[1] <= ex_regwrite;
            ent_wr_reg[1]   <= ex_wr_reg;
            ent_avail[1]    <= ex_avail;
            for (int k = 2; k <= int'(FWD_DEPTH); k++) begin
                ent_valid[k]    <= ent_valid[k-1];
                ent_regwrite[k] <= ent_regwrite[k-1];
                ent_wr_reg[k]   <= ent_wr_reg[k-1];
                ent_avail[k]    <= ent_avail[k-1];
            end
            if (flush || stall) begin
                ex_valid <= 1'b0;
            end else begin
                ex_valid    <= id_valid;
                ex_regwrite <= id_regwrite;
                ex_is_load  <= id_is_load;
                ex_wr_reg   <= id_wr_reg;
                ex_src      <= id_src_arr;
                ex_src_used <= id_src_used;
            end
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule
